apb_uart_loader: RTL and testbench

- Byte-stream-to-APB initiator bridge. It lets an external host read and write any APB target (RAM preload, peripheral poke) through a byte channel, typically wired to the UART receive and transmit byte streams.
- It drives an APB initiator port into the fabric. It is the initiator-side counterpart of the fabric's target ports and sits alongside the core's initiator port through an arbiter.
- Frames are parsed one byte at a time, each frame produces one 32-bit APB transfer, and status and read data are returned as response bytes.

---
 rtl/apb_uart_loader.sv | 193 +++++++++++++++++++
 tb/tb_apb_uart_loader.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_loader.sv
// apb_uart_loader: byte-stream command parser driving one 32-bit APB transfer per frame.
// Write frame: OP_WR A0..A3 D0..D3, read frame: OP_RD A0..A3 (little-endian fields).
// Responses: a status byte, followed by 4 read-data bytes (LSB first) for reads.
module apb_uart_loader #(
    parameter int unsigned ADDR_W = 32,
    parameter logic [7:0]  OP_WR  = 8'h57,
    parameter logic [7:0]  OP_RD  = 8'h52
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              psel,
    output logic              penable,
    input  logic              pready,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic [31:0]       pwdata,
    output logic [3:0]        pwstrb,
    input  logic [31:0]       prdata,
    input  logic              pslverr
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        SETUP  = 3'd3,
        ACCESS = 3'd4,
        RESP   = 3'd5
    } state_t;

    state_t              state_q;
    logic [1:0]          cnt_q;
    logic                is_wr_q;
    logic [31:0]         addr_buf_q;
    logic [23:0]         data_buf_q;
    logic [31:0]         resp_q;
    logic [2:0]          remain_q;
    logic                rx_ready_q;
    logic [7:0]          tx_data_q;
    logic                tx_valid_q;
    logic                psel_q;
    logic                penable_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [31:0]         pwdata_q;
    logic [3:0]          pwstrb_q;

    logic consume;

    assign consume  = rx_valid && rx_ready_q;

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign psel     = psel_q;
    assign penable  = penable_q;
    assign paddr    = paddr_q;
    assign pwrite   = pwrite_q;
    assign pwdata   = pwdata_q;
    assign pwstrb   = pwstrb_q;

    // Frame parser, APB initiator and response serializer in one registered FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            is_wr_q    <= 1'b0;
            addr_buf_q <= 32'd0;
            data_buf_q <= 24'd0;
            resp_q     <= 32'd0;
            remain_q   <= 3'd0;
            rx_ready_q <= 1'b0;
            tx_data_q  <= 8'd0;
            tx_valid_q <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= '0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 32'd0;
            pwstrb_q   <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    rx_ready_q <= 1'b1;
                    cnt_q      <= 2'd0;
                    if (consume) begin
                        if (rx_data == OP_WR || rx_data == OP_RD) begin
                            is_wr_q <= (rx_data == OP_WR);
                            state_q <= ADDR;
                        end else begin
                            tx_data_q  <= 8'hFF;
                            remain_q   <= 3'd0;
                            tx_valid_q <= 1'b1;
                            rx_ready_q <= 1'b0;
                            state_q    <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (consume) begin
                        cnt_q <= cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: addr_buf_q[7:0]   <= rx_data;
                            2'd1: addr_buf_q[15:8]  <= rx_data;
                            2'd2: addr_buf_q[23:16] <= rx_data;
                            default: begin
                                addr_buf_q[31:24] <= rx_data;
                                if (addr_buf_q[1:0] != 2'b00) begin
                                    // Misaligned: report and skip the bus access entirely.
                                    tx_data_q  <= 8'h02;
                                    remain_q   <= 3'd0;
                                    tx_valid_q <= 1'b1;
                                    rx_ready_q <= 1'b0;
                                    state_q    <= RESP;
                                end else if (is_wr_q) begin
                                    state_q <= DATA;
                                end else begin
                                    paddr_q    <= ADDR_W'({rx_data, addr_buf_q[23:0]});
                                    pwrite_q   <= 1'b0;
                                    pwstrb_q   <= 4'h0;
                                    psel_q     <= 1'b1;
                                    rx_ready_q <= 1'b0;
                                    state_q    <= SETUP;
                                end
                            end
                        endcase
                    end
                end
                DATA: begin
                    if (consume) begin
                        cnt_q <= cnt_q + 2'd1;
                        case (cnt_q)
                            2'd0: data_buf_q[7:0]   <= rx_data;
                            2'd1: data_buf_q[15:8]  <= rx_data;
                            2'd2: data_buf_q[23:16] <= rx_data;
                            default: begin
                                pwdata_q   <= {rx_data, data_buf_q};
                                paddr_q    <= ADDR_W'(addr_buf_q);
                                pwrite_q   <= 1'b1;
                                pwstrb_q   <= 4'hF;
                                psel_q     <= 1'b1;
                                rx_ready_q <= 1'b0;
                                state_q    <= SETUP;
                            end
                        endcase
                    end
                end
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (pready) begin
                        psel_q     <= 1'b0;
                        penable_q  <= 1'b0;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= pslverr ? 8'h01 : 8'h00;
                        state_q    <= RESP;
                        if (pwrite_q) begin
                            remain_q <= 3'd0;
                        end else begin
                            resp_q   <= pslverr ? 32'd0 : prdata;
                            remain_q <= 3'd4;
                        end
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        if (remain_q == 3'd0) begin
                            tx_valid_q <= 1'b0;
                            rx_ready_q <= 1'b1;
                            state_q    <= IDLE;
                        end else begin
                            tx_data_q <= resp_q[7:0];
                            resp_q    <= resp_q >> 8;
                            remain_q  <= remain_q - 3'd1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_loader.sv
// tb_apb_uart_loader: directed frame vectors plus backpressure and reset-in-ACCESS sequences.
module tb_apb_uart_loader;

    localparam int unsigned ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_ready;
    logic              psel;
    logic              penable;
    logic              pready = 1'b0;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [31:0]       pwdata;
    logic [3:0]        pwstrb;
    logic [31:0]       prdata = 32'd0;
    logic              pslverr = 1'b0;

    apb_uart_loader #(.ADDR_W(ADDR_W), .OP_WR(8'h57), .OP_RD(8'h52)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .psel(psel), .penable(penable), .pready(pready),
        .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pwstrb(pwstrb),
        .prdata(prdata), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [71:0] frm;
        logic [3:0]  nfrm;
        logic [3:0]  nwait;
        logic [31:0] rdata;
        logic        err;
        logic        bus;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        wr;
        logic [3:0]  strb;
        logic [39:0] tx;
        logic [2:0]  ntx;
    } vec_t;

    vec_t vecs[8];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int          cfg_wait = 0;
    logic [31:0] cfg_rdata = 32'd0;
    logic        cfg_err = 1'b0;

    int          wcnt = 0;
    int          setup_n = 0;
    int          access_n = 0;
    int          m_cyc = 0;
    int          first_tx = 0;
    int          last_tx = 0;
    logic        tx_valid_prev = 1'b0;
    logic [31:0] cap_addr = 32'd0;
    logic [31:0] cap_wdata = 32'd0;
    logic        cap_wr = 1'b0;
    logic [3:0]  cap_strb = 4'd0;
    logic [7:0]  txq[$];

    always @(posedge clk) cyc <= cyc + 1;

    // APB target with programmable wait states, bus monitor and tx sink collector.
    always @(negedge clk) begin
        if (psel && penable) begin
            access_n  <= access_n + 1;
            cap_addr  <= paddr;
            cap_wdata <= pwdata;
            cap_wr    <= pwrite;
            cap_strb  <= pwstrb;
            if (wcnt >= cfg_wait) begin
                pready  <= 1'b1;
                prdata  <= cfg_rdata;
                pslverr <= cfg_err;
                m_cyc   <= cyc;
            end else begin
                pready <= 1'b0;
                wcnt   <= wcnt + 1;
            end
        end else begin
            pready <= 1'b0;
            wcnt   <= 0;
            if (psel) setup_n <= setup_n + 1;
        end
        tx_valid_prev <= tx_valid;
        if (tx_valid && !tx_valid_prev) first_tx <= cyc;
        if (tx_valid && tx_ready) begin
            txq.push_back(tx_data);
            last_tx <= cyc;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        while (!rx_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!rx_ready) chk("rx_accept_timeout", 64'(n), 64'd0);
        @(posedge clk);
        #1 rx_valid = 1'b0;
    endtask

    task automatic wait_tx(input int base, input int cnt);
        int n;
        n = 0;
        while (txq.size() - base < cnt && n < 300) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int base, s0, a0;
        logic [7:0] b;
        logic [7:0] e;
        base = txq.size();
        s0 = setup_n;
        a0 = access_n;
        cfg_wait  = int'(v.nwait);
        cfg_rdata = v.rdata;
        cfg_err   = v.err;
        tx_ready  = 1'b1;
        for (int i = 0; i < int'(v.nfrm); i++) begin
            b = v.frm[8*i +: 8];
            send_byte(b);
        end
        if (v.bus) chk($sformatf("v%0d_setup_lat", idx), 64'({psel, penable}), 64'b10);
        wait_tx(base, int'(v.ntx));
        chk($sformatf("v%0d_tx_count", idx), 64'(txq.size() - base), 64'(v.ntx));
        @(negedge clk);
        chk($sformatf("v%0d_idle_ready", idx), 64'({rx_ready, tx_valid}), 64'b10);
        if (txq.size() - base >= int'(v.ntx)) begin
            for (int i = 0; i < int'(v.ntx); i++) begin
                e = v.tx[8*i +: 8];
                chk($sformatf("v%0d_tx_byte%0d", idx, i), 64'(txq[base+i]), 64'(e));
            end
        end
        chk($sformatf("v%0d_setup_cycles", idx), 64'(setup_n - s0), v.bus ? 64'd1 : 64'd0);
        chk($sformatf("v%0d_access_cycles", idx), 64'(access_n - a0),
            v.bus ? 64'(int'(v.nwait) + 1) : 64'd0);
        if (v.bus) begin
            chk($sformatf("v%0d_paddr", idx), 64'(cap_addr), 64'(v.addr));
            chk($sformatf("v%0d_pwrite", idx), 64'(cap_wr), 64'(v.wr));
            chk($sformatf("v%0d_pwstrb", idx), 64'(cap_strb), 64'(v.strb));
            if (v.wr) chk($sformatf("v%0d_pwdata", idx), 64'(cap_wdata), 64'(v.wdata));
            chk($sformatf("v%0d_resp_lat", idx), 64'(first_tx - m_cyc), 64'd1);
            if (v.ntx == 3'd5) chk($sformatf("v%0d_last_lat", idx), 64'(last_tx - m_cyc), 64'd5);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, base, bad;
        logic [7:0] held;
        logic [39:0] bp_exp;

        vecs[0] = '{frm:72'hDE_AD_BE_EF_00_00_10_00_57, nfrm:4'd9, nwait:4'd0, rdata:32'h0, err:1'b0,
                    bus:1'b1, addr:32'h0000_1000, wdata:32'hDEAD_BEEF, wr:1'b1, strb:4'hF,
                    tx:40'h00, ntx:3'd1};
        vecs[1] = '{frm:72'h00_00_10_04_52, nfrm:4'd5, nwait:4'd3, rdata:32'h1234_5678, err:1'b0,
                    bus:1'b1, addr:32'h0000_1004, wdata:32'h0, wr:1'b0, strb:4'h0,
                    tx:40'h12_34_56_78_00, ntx:3'd5};
        vecs[2] = '{frm:72'h00_00_00_08_52, nfrm:4'd5, nwait:4'd1, rdata:32'hAABB_CCDD, err:1'b1,
                    bus:1'b1, addr:32'h0000_0008, wdata:32'h0, wr:1'b0, strb:4'h0,
                    tx:40'h00_00_00_00_01, ntx:3'd5};
        vecs[3] = '{frm:72'h00_00_00_02_52, nfrm:4'd5, nwait:4'd0, rdata:32'h0, err:1'b0,
                    bus:1'b0, addr:32'h0, wdata:32'h0, wr:1'b0, strb:4'h0,
                    tx:40'h02, ntx:3'd1};
        vecs[4] = '{frm:72'h11_22_33_44_00_00_20_00_57, nfrm:4'd9, nwait:4'd2, rdata:32'h0, err:1'b1,
                    bus:1'b1, addr:32'h0000_2000, wdata:32'h1122_3344, wr:1'b1, strb:4'hF,
                    tx:40'h01, ntx:3'd1};
        vecs[5] = '{frm:72'h41, nfrm:4'd1, nwait:4'd0, rdata:32'h0, err:1'b0,
                    bus:1'b0, addr:32'h0, wdata:32'h0, wr:1'b0, strb:4'h0,
                    tx:40'hFF, ntx:3'd1};
        vecs[6] = '{frm:72'h04_03_02_01_80_00_00_10_57, nfrm:4'd9, nwait:4'd0, rdata:32'h0, err:1'b0,
                    bus:1'b1, addr:32'h8000_0010, wdata:32'h0403_0201, wr:1'b1, strb:4'hF,
                    tx:40'h00, ntx:3'd1};
        vecs[7] = '{frm:72'h00_00_00_00_52, nfrm:4'd5, nwait:4'd0, rdata:32'hCAFE_F00D, err:1'b0,
                    bus:1'b1, addr:32'h0000_0000, wdata:32'h0, wr:1'b0, strb:4'h0,
                    tx:40'hCA_FE_F0_0D_00, ntx:3'd5};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'd0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 64'({psel, penable, pwrite, tx_valid, rx_ready, pwstrb}), 64'd0);
        chk("rst_paddr", 64'(paddr), 64'd0);
        chk("rst_pwdata", 64'(pwdata), 64'd0);
        chk("rst_txdata", 64'(tx_data), 64'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Backpressure: sink stalls for 10 cycles at the start of a read response.
        base      = txq.size();
        tx_ready  = 1'b0;
        cfg_wait  = 0;
        cfg_rdata = 32'h0BAD_F00D;
        cfg_err   = 1'b0;
        send_byte(8'h52); send_byte(8'h0C); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n = 0;
        while (!tx_valid && n < 50) begin
            @(posedge clk);
            #1 n++;
        end
        chk("bp_tx_valid", 64'(tx_valid), 64'd1);
        held = tx_data;
        chk("bp_first_byte", 64'(held), 64'h00);
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (tx_data !== held || tx_valid !== 1'b1 || rx_ready !== 1'b0) bad++;
        end
        chk("bp_hold", 64'(bad), 64'd0);
        chk("bp_no_xfer", 64'(txq.size() - base), 64'd0);
        tx_ready = 1'b1;
        wait_tx(base, 5);
        chk("bp_tx_count", 64'(txq.size() - base), 64'd5);
        bp_exp = 40'h0B_AD_F0_0D_00;
        if (txq.size() - base >= 5) begin
            for (int i = 0; i < 5; i++)
                chk($sformatf("bp_tx_byte%0d", i), 64'(txq[base+i]), 64'(bp_exp[8*i +: 8]));
        end
        @(negedge clk);
        chk("bp_idle_ready", 64'({rx_ready, tx_valid}), 64'b10);
        @(posedge clk);
        #1;

        // Reset asserted in the middle of a long ACCESS phase.
        cfg_wait = 20;
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n = 0;
        while (!(psel && penable) && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        chk("rstacc_in_access", 64'({psel, penable}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("rstacc_async", 64'({psel, penable, tx_valid, rx_ready}), 64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cfg_wait = 0;
        run_vec(vecs[0], 8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
